// File: rtl/keypad_conditioner_pkg.sv
// Shared key indices and width helpers for the keypad front end and the lock FSM.
package keypad_conditioner_pkg;

  localparam int N_KEYS_DEFAULT = 4;

  localparam int KEY_A = 0;
  localparam int KEY_B = 1;
  localparam int KEY_C = 2;
  localparam int KEY_D = 3;

  // A single key still needs a one-bit code field.
  function automatic int code_width(input int n_keys);
    return (n_keys > 1) ? $clog2(n_keys) : 1;
  endfunction

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int KEY_CODE_W = code_width(N_KEYS_DEFAULT);

  typedef logic [KEY_CODE_W-1:0] key_code_t;

endpackage

// File: rtl/keypad_conditioner_if.sv
// Button inputs and conditioned key events between the keypad front end and its consumer.
interface keypad_conditioner_if
  import keypad_conditioner_pkg::*;
#(
  parameter int N_KEYS = N_KEYS_DEFAULT
);

  localparam int CODE_W = code_width(N_KEYS);

  logic [N_KEYS-1:0] btn_raw;
  logic [N_KEYS-1:0] level_out;
  logic [N_KEYS-1:0] press;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              multi_press;

  modport master (
    input  btn_raw,
    output level_out,
    output press,
    output key_valid,
    output key_code,
    output multi_press
  );

  modport slave (
    output btn_raw,
    input  level_out,
    input  press,
    input  key_valid,
    input  key_code,
    input  multi_press
  );

endinterface

// File: rtl/keypad_conditioner_key_debounce_cell.sv
// One key: input synchroniser, stable-count debounce filter and rising-edge press pulse.
module key_debounce_cell
  import keypad_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic press_nxt_o
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   db_prev_q;
  logic                   press_q, press_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
  assign sync_s = sync_q[SYNC_STAGES-1];

  // Any agreement between the synchronised input and the debounced level restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync_s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = sync_s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  assign press_d = db_q & ~db_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
      press_q   <= press_d;
    end
  end

  assign level_o     = db_q;
  assign press_o     = press_q;
  assign press_nxt_o = press_d;

endmodule

// File: rtl/keypad_conditioner.sv
// Keypad front end: per-key debounce cells plus a registered priority encoder and multi-press flag.
module keypad_conditioner
  import keypad_conditioner_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEFAULT,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  keypad_conditioner_if.master bus
);

  localparam int CODE_W = code_width(N_KEYS);

  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] press_nxt;

  logic              key_valid_q, key_valid_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              multi_q, multi_d;

  function automatic logic [CODE_W-1:0] lowest_index(input logic [N_KEYS-1:0] v);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (v[i]) code = CODE_W'(i);
    end
    return code;
  endfunction

  // True once a second set bit is seen, i.e. popcount > 1.
  function automatic logic more_than_one(input logic [N_KEYS-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (v[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    return multi;
  endfunction

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce_cell #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .btn_i      (bus.btn_raw[k]),
      .level_o    (level[k]),
      .press_o    (press[k]),
      .press_nxt_o(press_nxt[k])
    );
  end

  // Decoded from the next press vector so the summary outputs register alongside press.
  always_comb begin
    key_valid_d = |press_nxt;
    key_code_d  = lowest_index(press_nxt);
    multi_d     = more_than_one(press_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      multi_q     <= 1'b0;
    end else begin
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      multi_q     <= multi_d;
    end
  end

  assign bus.level_out   = level;
  assign bus.press       = press;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_code    = key_code_q;
  assign bus.multi_press = multi_q;

endmodule

// File: tb/tb_keypad_conditioner.sv
// Directed scoreboard bench for keypad_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_keypad_conditioner;
  import keypad_conditioner_pkg::*;

  localparam int NK  = 4;
  localparam int SS  = 2;
  localparam int DC  = 4;
  localparam int LAT = SS + DC;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  keypad_conditioner_if #(.N_KEYS(NK)) bus ();

  keypad_conditioner #(
    .N_KEYS         (NK),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [1:0] code;
    logic       multi;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every presented key event must match the head of the scoreboard, on the expected cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missing_pulse cyc=%0d want press=%b at cyc=%0d", cyc, mon_e.press, mon_e.cyc);
    end
    if (bus.key_valid || bus.press != 4'b0000 || bus.multi_press) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d press=%b valid=%b code=%0d multi=%b",
                 cyc, bus.press, bus.key_valid, bus.key_code, bus.multi_press);
      end else begin
        mon_e = sb.pop_front();
        if (cyc != mon_e.cyc || bus.press != mon_e.press || !bus.key_valid ||
            bus.key_code != mon_e.code || bus.multi_press != mon_e.multi) begin
          bad++;
          $display("FAIL press_event got cyc=%0d press=%b valid=%b code=%0d multi=%b want cyc=%0d press=%b valid=1 code=%0d multi=%b",
                   cyc, bus.press, bus.key_valid, bus.key_code, bus.multi_press,
                   mon_e.cyc, mon_e.press, mon_e.code, mon_e.multi);
        end
      end
    end else begin
      total++;
      if (bus.key_code != 2'd0) begin
        bad++;
        $display("FAIL idle_code cyc=%0d got=%0d want=0", cyc, bus.key_code);
      end
    end
  end

  task automatic go(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  task automatic push(input int c, input logic [3:0] p, input int code, input logic m);
    exp_t e;
    e.cyc   = c;
    e.press = p;
    e.code  = 2'(code);
    e.multi = m;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.level_out, bus.press, bus.key_valid, bus.key_code, bus.multi_press});
  endfunction

  initial begin
    int c;
    bus.btn_raw = 4'b1111;
    rst = 1'b1;

    // Reset held with all keys pressed.
    repeat (3) begin
      @(negedge clk);
      chk("reset_zero", all_outs(), 32'd0);
    end
    rst = 1'b0;
    c = cyc;
    push(c + LAT + 1, 4'b1111, KEY_A, 1'b1);
    go(c + LAT - 1); chk("post_rst_lvl_early", 32'(bus.level_out), 32'h0);
    go(c + LAT);     chk("post_rst_lvl", 32'(bus.level_out), 32'hf);
    go(c + LAT + 4);
    bus.btn_raw = 4'b0000;
    c = cyc;
    go(c + LAT + 4); chk("release_all_lvl", 32'(bus.level_out), 32'h0);

    // Clean press on key B, then a long hold.
    bus.btn_raw = 4'b0010;
    c = cyc;
    push(c + LAT + 1, 4'b0010, KEY_B, 1'b0);
    go(c + LAT - 1); chk("clean_lvl_early", 32'(bus.level_out), 32'h0);
    go(c + LAT);     chk("clean_lvl", 32'(bus.level_out), 32'h2);
    go(c + LAT + 50); chk("clean_hold_lvl", 32'(bus.level_out), 32'h2);
    bus.btn_raw = 4'b0000;
    c = cyc;
    go(c + LAT + 4);

    // Bounce on key C: 3 high / 1 low never completes the count.
    for (int i = 0; i < 5; i++) begin
      bus.btn_raw = 4'b0100;
      go(cyc + 3);
      bus.btn_raw = 4'b0000;
      go(cyc + 1);
      chk("bounce_lvl", 32'(bus.level_out), 32'h0);
    end
    go(cyc + LAT);
    chk("bounce_settled_lvl", 32'(bus.level_out), 32'h0);
    bus.btn_raw = 4'b0100;
    c = cyc;
    push(c + LAT + 1, 4'b0100, KEY_C, 1'b0);
    go(c + LAT); chk("bounce_then_hold_lvl", 32'(bus.level_out), 32'h4);
    go(c + LAT + 4);
    bus.btn_raw = 4'b0000;
    go(cyc + LAT + 4);

    // Key D: press, one-cycle dropout, real release, re-press.
    bus.btn_raw = 4'b1000;
    c = cyc;
    push(c + LAT + 1, 4'b1000, KEY_D, 1'b0);
    go(c + LAT + 4);
    bus.btn_raw = 4'b0000;
    go(cyc + 1);
    bus.btn_raw = 4'b1000;
    go(cyc + 10);
    chk("glitch_lvl", 32'(bus.level_out), 32'h8);
    bus.btn_raw = 4'b0000;
    c = cyc;
    go(c + LAT); chk("release_d_lvl", 32'(bus.level_out), 32'h0);
    go(c + 10);
    bus.btn_raw = 4'b1000;
    c = cyc;
    push(c + LAT + 1, 4'b1000, KEY_D, 1'b0);
    go(c + LAT); chk("repress_d_lvl", 32'(bus.level_out), 32'h8);
    go(c + LAT + 4);
    bus.btn_raw = 4'b0000;
    go(cyc + LAT + 4);

    // Simultaneous A and C.
    bus.btn_raw = 4'b0101;
    c = cyc;
    push(c + LAT + 1, 4'b0101, KEY_A, 1'b1);
    go(c + LAT); chk("simul_lvl", 32'(bus.level_out), 32'h5);
    go(c + LAT + 4);
    bus.btn_raw = 4'b0000;
    go(cyc + LAT + 4);

    // Reset pulsed on the 4th edge of a key A debounce.
    bus.btn_raw = 4'b0001;
    c = cyc;
    go(c + 3);
    rst = 1'b1;
    go(c + 4);
    rst = 1'b0;
    chk("midrst_zero", all_outs(), 32'd0);
    push(c + 4 + LAT + 1, 4'b0001, KEY_A, 1'b0);
    go(c + 4 + LAT - 1); chk("midrst_lvl_early", 32'(bus.level_out), 32'h0);
    go(c + 4 + LAT);     chk("midrst_lvl", 32'(bus.level_out), 32'h1);
    go(c + 4 + LAT + 6);

    chk("all_pulses_seen", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
